// File: rtl/reduce_out_router.sv
// reduce_out_router
//
// Last stage of the per-node reduction unit in the 2x2x2 MPI collective
// network. Finished reduction packets arrive as a one-cycle strobe with no
// backpressure and are buffered in a small FIFO. The FIFO head is routed by
// comparing its destination node with the local rank: local host, or the
// x, y or z neighbour, resolved x first. The chosen packet is held on a
// one-hot valid/ready egress until the selected consumer takes it.
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   in_packet    completed packet: [63] valid, [62] reduction, [61:59] src,
//                [58:56] dst, [55:0] payload
//   in_valid     one-cycle capture strobe from the reduction unit
//   out_packet   egress packet, shared by all four egress ports
//   out_valid    one-hot egress select: [0] host, [1] x, [2] y, [3] z
//   out_ready    per-port consumer ready, same bit order as out_valid
//   fifo_count   current FIFO occupancy
//   overflow     sticky flag, set when a packet is dropped on a full FIFO
//   drop_count   dropped packet count, saturating at 255

module reduce_out_router #(
  parameter logic [2:0] RANK       = 3'b000,
  parameter int         DataWidth  = 64,
  parameter int         FifoDepth  = 4,
  parameter int         CountWidth = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DataWidth-1:0]  in_packet,
  input  logic                  in_valid,
  output logic [DataWidth-1:0]  out_packet,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [CountWidth-1:0] fifo_count,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  // Header fields sit at fixed offsets from the top of the packet.
  localparam int ValidBit = DataWidth - 1;
  localparam int SrcLsb   = DataWidth - 5;
  localparam int DstLsb   = DataWidth - 8;
  localparam int PtrWidth = $clog2(FifoDepth);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                state_q, state_d;
  logic [DataWidth-1:0]  mem_q [FifoDepth];
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  logic [DataWidth-1:0]  out_packet_q, out_packet_d;
  logic [3:0]            out_valid_q, out_valid_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            drop_count_q, drop_count_d;

  logic [DataWidth-1:0]  head;
  logic [DataWidth-1:0]  head_fwd;
  logic [2:0]            diff;
  logic [3:0]            route;
  logic                  fifo_nonempty;
  logic                  fifo_full;
  logic                  handshake;
  logic                  pop;
  logic                  push_req;
  logic                  push;
  logic                  drop;

  assign head          = mem_q[rd_ptr_q];
  assign fifo_nonempty = (count_q != '0);
  assign fifo_full     = (count_q == CountWidth'(FifoDepth));

  // Only the selected port's ready can complete a transfer; out_valid_q is
  // one-hot, so masking with it ignores every other ready bit.
  assign handshake = (state_q == SEND) && ((out_valid_q & out_ready) != 4'b0000);

  // The head is popped straight into the output register, either from IDLE
  // or on the completing edge of a transfer for back-to-back delivery.
  assign pop = fifo_nonempty && ((state_q == IDLE) || handshake);

  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign push_req = in_valid && in_packet[ValidBit];
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  // Dimension-order route on the head: host when dst matches, else the
  // lowest differing coordinate. Forwarded packets carry this node as src.
  always_comb begin
    diff     = head[DstLsb +: 3] ^ RANK;
    route    = 4'b0001;
    head_fwd = head;
    if (diff == 3'b000) begin
      route = 4'b0001;
    end else if (diff[0]) begin
      route = 4'b0010;
    end else if (diff[1]) begin
      route = 4'b0100;
    end else begin
      route = 4'b1000;
    end
    if (diff != 3'b000) begin
      head_fwd[SrcLsb +: 3] = RANK;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: SEND persists while packets keep arriving at the head.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (handshake && !fifo_nonempty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: load on pop, clear on a completion with nothing behind it,
  // otherwise hold so the egress stays stable while the consumer stalls.
  always_comb begin
    out_packet_d = out_packet_q;
    out_valid_d  = out_valid_q;
    if (pop) begin
      out_packet_d = head_fwd;
      out_valid_d  = route;
    end else if (handshake) begin
      out_valid_d  = 4'b0000;
    end
  end

  // FIFO bookkeeping plus the drop statistics.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + PtrWidth'(push);
    rd_ptr_d     = rd_ptr_q + PtrWidth'(pop);
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CountWidth'(1);
      2'b01:   count_d = count_q - CountWidth'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 8'd1;
      end
    end
  end

  // Control and egress registers; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_packet_q <= '0;
      out_valid_q  <= 4'b0000;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_packet_q <= out_packet_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_packet;
    end
  end

  assign out_packet = out_packet_q;
  assign out_valid  = out_valid_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
